phy_tx_feeder: RTL and testbench

- Word-rate feeder sitting directly upstream of the PHY transmit path; drives the PHY's valid_in / Data_in pair.
- Accepts 32-bit words from the link layer in bursts on clk_32f and buffers them in a small FIFO.
- Presents one word per word period of WORD_CYCLES clk_32f cycles, held stable for the whole period, so the serializer always sees a steady word.
- Emits valid_out=0 with data_out=0 when nothing is queued.

---
 rtl/phy_tx_feeder.sv | 115 +++++++++++
 tb/tb_phy_tx_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_feeder.sv
// rtl/phy_tx_feeder.sv - word-rate FIFO feeder presenting one held word per WORD_CYCLES to the PHY
// Optional statistics counters are enabled with `define PHY_TX_FEEDER_STATS_EN.
module phy_tx_feeder #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int WORD_CYCLES = 32,
    parameter int AF_THRESH   = 6
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              push,
    input  logic [31:0]       push_data,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              valid_out,
    output logic [31:0]       data_out,
    output logic              word_strobe,
    output logic [ADDR_W:0]   occupancy
`ifdef PHY_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]       words_sent,
    output logic [15:0]       idle_periods
`endif
);

    localparam int CNT_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   OCC_AF   = (ADDR_W + 1)'(AF_THRESH);

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       mem [DEPTH];
    logic              boundary;
    logic              push_ok;
    logic              pop;
    logic [ADDR_W:0]   occ_next;

    assign boundary = (cnt == CNT_LAST);
    // A full FIFO refuses pushes even when the same edge pops; the flag is pre-edge.
    assign push_ok  = push & ~full;
    assign pop      = boundary & (occupancy != '0);

    always_comb begin
        occ_next = occupancy;
        if (push_ok && !pop) begin
            occ_next = occupancy + OCC_ONE;
        end else if (!push_ok && pop) begin
            occ_next = occupancy - OCC_ONE;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            word_strobe <= 1'b0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CNT_ONE;
            word_strobe <= boundary;
            occupancy   <= occ_next;
            full        <= (occ_next == OCC_FULL);
            almost_full <= (occ_next >= OCC_AF);
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
            // The output word only ever changes at a period boundary.
            if (boundary) begin
                valid_out <= pop;
                data_out  <= pop ? mem[rd_ptr] : '0;
            end
        end
    end

`ifdef PHY_TX_FEEDER_STATS_EN
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            words_sent   <= '0;
            idle_periods <= '0;
        end else if (boundary) begin
            if (pop && words_sent != 16'hFFFF) begin
                words_sent <= words_sent + 16'd1;
            end
            if (!pop && idle_periods != 16'hFFFF) begin
                idle_periods <= idle_periods + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_feeder.sv
// tb/tb_phy_tx_feeder.sv - self-checking bench for phy_tx_feeder against a queue-based model
module tb_phy_tx_feeder;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] push_data;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        valid_out;
    logic [31:0] data_out;
    logic        word_strobe;
    logic [3:0]  occupancy;
`ifdef PHY_TX_FEEDER_STATS_EN
    logic [15:0] words_sent;
    logic [15:0] idle_periods;
`endif

    phy_tx_feeder dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .word_strobe (word_strobe),
        .occupancy   (occupancy)
`ifdef PHY_TX_FEEDER_STATS_EN
        ,
        .words_sent  (words_sent),
        .idle_periods(idle_periods)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: cycle index since reset, a queue of pending words, the held output word.
    int          m_cyc  = 0;
    bit          m_live = 0;
    logic [31:0] q[$];
    logic        m_valid, m_ws, m_over;
    logic [31:0] m_data;
    int          m_sent, m_idle;

    always @(posedge clk_32f) begin
        int  pre;
        bit  bnd;
        if (reset) begin
            m_cyc = 0; q.delete();
            m_valid = 0; m_data = 0; m_ws = 0; m_over = 0;
            m_sent = 0; m_idle = 0; m_live = 1;
        end else begin
            bnd  = (m_cyc % 32) == 31;
            pre  = q.size();
            m_ws = bnd;
            if (bnd) begin
                if (pre > 0) begin
                    m_data = q.pop_front(); m_valid = 1;
                    if (m_sent < 65535) m_sent++;
                end else begin
                    m_data = 0; m_valid = 0;
                    if (m_idle < 65535) m_idle++;
                end
            end
            if (push) begin
                if (pre < 8) q.push_back(push_data);
                else m_over = 1;
            end
            m_cyc++;
        end
    end

    always @(negedge clk_32f) begin
        if (m_live) begin
            chk("valid_out",   32'(valid_out),   32'(m_valid));
            chk("data_out",    data_out,         m_data);
            chk("word_strobe", 32'(word_strobe), 32'(m_ws));
            chk("overflow",    32'(overflow),    32'(m_over));
            chk("occupancy",   32'(occupancy),   32'(q.size()));
            chk("full",        32'(full),        32'(q.size() == 8));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
`ifdef PHY_TX_FEEDER_STATS_EN
            chk("words_sent",   32'(words_sent),   32'(m_sent));
            chk("idle_periods", 32'(idle_periods), 32'(m_idle));
`endif
        end
    end

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (m_cyc < t && guard < 5000) begin
            @(negedge clk_32f);
            guard++;
        end
        if (m_cyc < t) begin
            n_total++;
            $display("FAIL wait_cyc: reached cycle %0d expected %0d", m_cyc, t);
        end
    endtask

    task automatic push_at(input int t, input logic [31:0] d);
        wait_cyc(t);
        push = 1'b1; push_data = d;
        @(negedge clk_32f);
        push = 1'b0; push_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; push_data = '0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;

        // Idle after reset
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data",  data_out,       32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        wait_cyc(31); chk("idle_ws31", 32'(word_strobe), 32'd0);
        wait_cyc(32); chk("idle_ws32", 32'(word_strobe), 32'd1);
        wait_cyc(33); chk("idle_ws33", 32'(word_strobe), 32'd0);
        wait_cyc(64); chk("idle_ws64", 32'(word_strobe), 32'd1);
        wait_cyc(96); chk("idle_ws96", 32'(word_strobe), 32'd1);
        wait_cyc(100);
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_ovf",   32'(overflow),  32'd0);

        // Single word pushed at cycle 5
        do_reset();
        push_at(5, 32'hA5A5_0001);
        wait_cyc(32);
        chk("single_valid32", 32'(valid_out), 32'd1);
        chk("single_data32",  data_out,       32'hA5A5_0001);
        wait_cyc(63); chk("single_data63", data_out, 32'hA5A5_0001);
        wait_cyc(64);
        chk("single_valid64", 32'(valid_out), 32'd0);
        chk("single_data64",  data_out,       32'd0);

        // Burst of 8, then a dropped 9th
        do_reset();
        for (int i = 0; i < 6; i++) push_at(1 + i, 32'(i));
        chk("burst_af6",   32'(almost_full), 32'd1);
        chk("burst_full6", 32'(full),        32'd0);
        chk("burst_occ6",  32'(occupancy),   32'd6);
        for (int i = 6; i < 8; i++) push_at(1 + i, 32'(i));
        chk("burst_full8", 32'(full), 32'd1);
        push_at(9, 32'hDEAD_BEEF);
        chk("burst_ovf",   32'(overflow),  32'd1);
        chk("burst_occ9",  32'(occupancy), 32'd8);
        for (int k = 0; k < 8; k++) begin
            wait_cyc(32 * (k + 1) + 1);
            chk("burst_word", data_out, 32'(k));
        end
        wait_cyc(32 * 9 + 1);
        chk("burst_drain", 32'(valid_out), 32'd0);

        // Push on the boundary cycle into an empty FIFO
        do_reset();
        push_at(31, 32'h0000_0077);
        chk("bnd_valid32", 32'(valid_out), 32'd0);
        chk("bnd_occ32",   32'(occupancy), 32'd1);
        wait_cyc(64);
        chk("bnd_valid64", 32'(valid_out), 32'd1);
        chk("bnd_data64",  data_out,       32'h0000_0077);

        // Full FIFO with push and pop on the same boundary
        do_reset();
        for (int i = 0; i < 8; i++) push_at(1 + i, 32'h10 + 32'(i));
        push_at(31, 32'h0000_CAFE);
        chk("fpp_ovf",  32'(overflow),  32'd1);
        chk("fpp_occ",  32'(occupancy), 32'd7);
        chk("fpp_data", data_out,       32'h10);
        wait_cyc(32 * 9 + 2);

        // Reset in the middle of a period with words queued
        do_reset();
        for (int i = 0; i < 3; i++) push_at(1 + i, 32'hB000 + 32'(i));
        wait_cyc(40);
        chk("mid_data40", data_out, 32'hB000);
        do_reset();
        chk("mid_valid", 32'(valid_out), 32'd0);
        chk("mid_occ",   32'(occupancy), 32'd0);
`ifdef PHY_TX_FEEDER_STATS_EN
        chk("mid_sent", 32'(words_sent),   32'd0);
        chk("mid_idle", 32'(idle_periods), 32'd0);
`endif
        wait_cyc(31); chk("mid_ws31", 32'(word_strobe), 32'd0);
        wait_cyc(32);
        chk("mid_ws32",    32'(word_strobe), 32'd1);
        chk("mid_valid32", 32'(valid_out),   32'd0);
        wait_cyc(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
